dp_add_result_stage: RTL and testbench
======================================

Name: dp_add_result_stage

Overview:
Registered result stage directly downstream of the combinational dp_adder. It accepts the adder's operands and result through a valid/ready handshake and buffers them in a small in-order FIFO. Each result is classified and given per-operation exception flags. A sticky status register accumulates those flags as results are consumed, which gives the FPU a timing boundary, backpressure tolerance and an fflags-style status.

Parameters:
DEPTH, 2, number of buffered result entries (power of two, >=2)
TAG_W, 4, width of the caller tag carried alongside each result

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream presents operands + adder result
in_ready  out  1  stage can accept this cycle
in_a  in  64  operand a as given to dp_adder
in_b  in  64  operand b as given to dp_adder
in_result  in  64  dp_adder result for in_a/in_b
in_tag  in  TAG_W  caller tag, returned unchanged
out_valid  out  1  head entry available
out_ready  in  1  downstream consumes head entry
out_result  out  64  buffered result
out_tag  out  TAG_W  buffered tag
out_class  out  4  one-hot {nan, inf, zero, subnormal}; all zero = normal
out_flags  out  3  per-op {invalid, overflow, tiny}
sticky_flags  out  3  accumulated {invalid, overflow, tiny}
flags_clr  in  1  synchronous clear of sticky_flags
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst=1): FIFO empty; count=0, out_valid=0, sticky_flags=0, in_ready=0 while rst is high, 1 after release. out_result/out_tag/out_class/out_flags read 0 when empty.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count < DEPTH). There is no full-and-pop bypass; when full, in_ready stays 0 even if out_ready=1.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- Latency: a push into an empty FIFO gives out_valid=1 on the next edge. Outputs are driven from registered storage only, with no combinational path from in_* to out_*.
- Pointers: wr/rd pointers wrap modulo DEPTH; count tracks occupancy; out_valid = (count != 0).
- Classification of in_result, computed at push and stored:
  - nan: exp==7FF, frac!=0
  - inf: exp==7FF, frac==0
  - zero: exp==0, frac==0 (either sign)
  - subnormal: exp==0, frac!=0
  - normal: otherwise (all class bits 0)
- Per-op flags, computed at push and stored:
  - invalid: either operand is an sNaN (exp 7FF, frac!=0, frac[51]==0), or the result is NaN and neither operand is NaN (covers inf-inf)
  - overflow: the result is inf and both operands are finite (exp!=7FF)
  - tiny: the result is subnormal
- Sticky update on each edge, in priority order:
  - if flags_clr and pop: sticky = popped out_flags
  - elif flags_clr: sticky = 0
  - elif pop: sticky |= popped out_flags
  - else: hold
- Reset mid-operation discards all buffered entries and clears sticky; nothing is emitted afterwards.
- in_* values outside a push cycle are ignored. out_* hold steady while out_valid && !out_ready.

Decomposition:
- Shared package fpu_pkg:
  - constants DP_EXP_W=11, DP_FRAC_W=52, DP_EXP_MAX=11'h7FF
  - class bit indices CLS_NAN=3, CLS_INF=2, CLS_ZERO=1, CLS_SUB=0
  - flag indices FLG_NV=2, FLG_OF=1, FLG_TINY=0
  - functions is_nan, is_snan, is_inf, is_zero, is_sub
- One natural sub-module: dp_classify, a combinational 64-bit word to 4-bit class plus snan bit, instantiated three times (in_a, in_b, in_result).
- The FIFO storage stays inline.

Test Plan:
- Basic normal result: push a=3FF0000000000000, b=3FF0000000000000, result=4000000000000000, tag=3, out_ready=1 -> next cycle out_valid=1, out_result=4000000000000000, out_tag=3, out_class=0, out_flags=0; sticky=0 after pop.
- Inf minus inf: a=7FF0000000000000, b=FFF0000000000000, result=7FF8000000000000 -> out_class=1000, out_flags=100; sticky=100 after pop.
- Overflow: a=b=7FEFFFFFFFFFFFFF, result=7FF0000000000000 -> out_class=0100, out_flags=010. Repeat with a=7FF0000000000000, b=3FF0000000000000 -> flags=000 (inf operand, no overflow).
- Subnormal result and sNaN operand: a=b=0000000000000001, result=0000000000000002 -> class=0001, flags=001. Then a=7FF0000000000001, b=3FF0000000000000, result=7FF8000000000000 -> flags=100.
- Backpressure: DEPTH=2, out_ready=0, push tags 1,2 -> in_ready=0, count=2, third push stalls. Raise out_ready -> tags emerge 1,2,3 in order. Push+pop same cycle keeps count=1.
- Clear/pop collision and reset: sticky=100, pop entry with flags 010 while flags_clr=1 -> sticky=010. Assert rst with 2 entries held -> count=0, out_valid=0, sticky=0 immediately, with no output after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared double-precision field constants, class/flag bit positions and
// IEEE-754 binary64 field predicates used by the FPU result path.
package fpu_pkg;

  localparam int         DP_EXP_W   = 11;
  localparam int         DP_FRAC_W  = 52;
  localparam logic [10:0] DP_EXP_MAX = 11'h7FF;

  localparam int CLS_NAN  = 3;
  localparam int CLS_INF  = 2;
  localparam int CLS_ZERO = 1;
  localparam int CLS_SUB  = 0;

  localparam int FLG_NV   = 2;
  localparam int FLG_OF   = 1;
  localparam int FLG_TINY = 0;

  // Per-entry metadata kept alongside each buffered result.
  typedef struct packed {
    logic [3:0] cls;
    logic [2:0] flags;
  } meta_t;

  function automatic logic [DP_EXP_W-1:0] dp_exp(input logic [63:0] w);
    return w[62:52];
  endfunction

  function automatic logic [DP_FRAC_W-1:0] dp_frac(input logic [63:0] w);
    return w[51:0];
  endfunction

  function automatic logic is_nan(input logic [63:0] w);
    return (dp_exp(w) == DP_EXP_MAX) && (dp_frac(w) != '0);
  endfunction

  // Signalling NaN has the quiet bit (frac MSB) clear.
  function automatic logic is_snan(input logic [63:0] w);
    return is_nan(w) && !w[51];
  endfunction

  function automatic logic is_inf(input logic [63:0] w);
    return (dp_exp(w) == DP_EXP_MAX) && (dp_frac(w) == '0);
  endfunction

  function automatic logic is_zero(input logic [63:0] w);
    return (dp_exp(w) == '0) && (dp_frac(w) == '0);
  endfunction

  function automatic logic is_sub(input logic [63:0] w);
    return (dp_exp(w) == '0) && (dp_frac(w) != '0);
  endfunction

endpackage

// File: rtl/dp_classify.sv
// Binary64 classifier: one-hot {nan, inf, zero, subnormal} plus signalling-NaN bit.
// Purely combinational, zero latency; no handshake.
module dp_classify
  import fpu_pkg::*;
(
  input  logic [63:0] word,
  output logic [3:0]  cls,
  output logic        snan
);

  assign cls[CLS_NAN]  = is_nan(word);
  assign cls[CLS_INF]  = is_inf(word);
  assign cls[CLS_ZERO] = is_zero(word);
  assign cls[CLS_SUB]  = is_sub(word);
  assign snan          = is_snan(word);

endmodule

// File: rtl/dp_add_result_stage.sv
// Registered result FIFO behind dp_adder: classifies each result, raises per-op flags, keeps sticky flags.
// Latency 1 cycle push-to-out_valid; in_ready drops when full (no full-and-pop bypass).
// Backpressure: out_* hold while out_valid && !out_ready; upstream stalls via in_ready.
module dp_add_result_stage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_a,
  input  logic [63:0]                in_b,
  input  logic [63:0]                in_result,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic [3:0]                 out_class,
  output logic [2:0]                 out_flags,
  output logic [2:0]                 sticky_flags,
  input  logic                       flags_clr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0] a_cls, b_cls, r_cls;
  logic       a_snan, b_snan, r_snan;

  dp_classify u_cls_a (.word(in_a),      .cls(a_cls), .snan(a_snan));
  dp_classify u_cls_b (.word(in_b),      .cls(b_cls), .snan(b_snan));
  dp_classify u_cls_r (.word(in_result), .cls(r_cls), .snan(r_snan));

  logic unused_cls;
  assign unused_cls = ^{a_cls[CLS_ZERO], a_cls[CLS_SUB], b_cls[CLS_ZERO], b_cls[CLS_SUB], r_snan};

  logic a_fin, b_fin;
  assign a_fin = !a_cls[CLS_NAN] && !a_cls[CLS_INF];
  assign b_fin = !b_cls[CLS_NAN] && !b_cls[CLS_INF];

  // A NaN result from non-NaN inputs (inf - inf) is an invalid operation.
  meta_t in_meta;
  always_comb begin
    in_meta                 = '0;
    in_meta.cls             = r_cls;
    in_meta.flags[FLG_NV]   = a_snan || b_snan ||
                              (r_cls[CLS_NAN] && !a_cls[CLS_NAN] && !b_cls[CLS_NAN]);
    in_meta.flags[FLG_OF]   = r_cls[CLS_INF] && a_fin && b_fin;
    in_meta.flags[FLG_TINY] = r_cls[CLS_SUB];
  end

  logic [63:0]      res_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  meta_t            meta_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          push, pop;
  meta_t         head_meta;

  assign in_ready  = !rst && (cnt < CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;
  assign head_meta = meta_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset: reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr]  <= in_result;
      tag_mem[wr_ptr]  <= in_tag;
      meta_mem[wr_ptr] <= in_meta;
    end
  end

  // A clear coinciding with a pop keeps the popped op's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (flags_clr && pop) begin
      sticky_flags <= head_meta.flags;
    end else if (flags_clr) begin
      sticky_flags <= '0;
    end else if (pop) begin
      sticky_flags <= sticky_flags | head_meta.flags;
    end
  end

  assign out_result = out_valid ? res_mem[rd_ptr] : '0;
  assign out_tag    = out_valid ? tag_mem[rd_ptr] : '0;
  assign out_class  = out_valid ? head_meta.cls   : '0;
  assign out_flags  = out_valid ? head_meta.flags : '0;

endmodule

// File: tb/tb_dp_add_result_stage.sv
// Self-checking bench for dp_add_result_stage: directed IEEE cases, backpressure,
// sticky clear collision, async reset, and randomized traffic against a queue model.
module tb_dp_add_result_stage;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_a, in_b, in_result;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_class;
  logic [2:0]       out_flags;
  logic [2:0]       sticky_flags;
  logic             flags_clr;
  logic [1:0]       count;

  dp_add_result_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_result(in_result), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_class(out_class), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .flags_clr(flags_clr), .count(count)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [63:0]      r;
    logic [TAG_W-1:0] tag;
    logic [3:0]       cls;
    logic [2:0]       fl;
  } exp_t;

  exp_t       mq[$];
  logic [2:0] m_sticky;

  // Reference: decode exponent/fraction as numbers and apply the IEEE rules directly.
  function automatic exp_t ref_entry(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] r, input logic [TAG_W-1:0] t);
    exp_t e;
    int unsigned ea, eb, er;
    longint unsigned fa, fb, fr;
    bit a_nan, b_nan, a_sn, b_sn, r_nan, r_inf, r_sub, r_zero;
    ea = a[62:52]; eb = b[62:52]; er = r[62:52];
    fa = a[51:0];  fb = b[51:0];  fr = r[51:0];
    a_nan  = (ea == 2047) && (fa != 0);
    b_nan  = (eb == 2047) && (fb != 0);
    a_sn   = a_nan && (fa < 64'h8_0000_0000_0000);
    b_sn   = b_nan && (fb < 64'h8_0000_0000_0000);
    r_nan  = (er == 2047) && (fr != 0);
    r_inf  = (er == 2047) && (fr == 0);
    r_zero = (er == 0) && (fr == 0);
    r_sub  = (er == 0) && (fr != 0);
    e.r   = r;
    e.tag = t;
    e.cls = {r_nan, r_inf, r_zero, r_sub};
    e.fl  = {a_sn || b_sn || (r_nan && !a_nan && !b_nan),
             r_inf && (ea != 2047) && (eb != 2047),
             r_sub};
    return e;
  endfunction

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] r, input logic [TAG_W-1:0] t);
    in_valid = v; in_a = a; in_b = b; in_result = r; in_tag = t;
  endtask

  // Advance one clock with the currently driven inputs and update the model.
  task automatic tick();
    bit         push, pop;
    logic [2:0] pf;
    exp_t       e;
    push = in_valid && (mq.size() < DEPTH);
    pop  = out_ready && (mq.size() > 0);
    pf   = pop ? mq[0].fl : 3'b000;
    e    = ref_entry(in_a, in_b, in_result, in_tag);
    @(posedge clk);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(e);
    if (flags_clr && pop) m_sticky = pf;
    else if (flags_clr)   m_sticky = 3'b000;
    else if (pop)         m_sticky = m_sticky | pf;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: w = {w[63], 11'h7FF, 52'h0};
      1: w = {w[63], 11'h7FF, 1'b1, w[50:0]};
      2: w = {w[63], 11'h7FF, 1'b0, w[50:1], 1'b1};
      3: w = {w[63], 63'h0};
      4: w = {w[63], 11'h000, w[51:1], 1'b1};
      5: w = 64'h7FEF_FFFF_FFFF_FFFF;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; flags_clr = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    mq.delete(); m_sticky = 3'b000;
    repeat (2) @(negedge clk);
    total++; if (count !== 2'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_held got=%b exp=0", in_ready); else passed++;
    total++; if (sticky_flags !== 3'b000) $display("FAIL reset_sticky got=%b exp=000", sticky_flags); else passed++;
    total++; if ({out_result, out_tag, out_class, out_flags} !== '0)
      $display("FAIL reset_outputs_zero got=%h/%h/%b/%b", out_result, out_tag, out_class, out_flags);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_classify();
    logic [63:0] va [7];
    logic [63:0] vb [7];
    logic [63:0] vr [7];
    logic [3:0]  vc [7];
    logic [2:0]  vf [7];
    va = '{64'h3FF0000000000000, 64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000,
           64'h0000000000000001, 64'h7FF0000000000001, 64'h0000000000000000};
    vb = '{64'h3FF0000000000000, 64'hFFF0000000000000, 64'h7FEFFFFFFFFFFFFF, 64'h3FF0000000000000,
           64'h0000000000000001, 64'h3FF0000000000000, 64'h8000000000000000};
    vr = '{64'h4000000000000000, 64'h7FF8000000000000, 64'h7FF0000000000000, 64'h7FF0000000000000,
           64'h0000000000000002, 64'h7FF8000000000000, 64'h8000000000000000};
    vc = '{4'b0000, 4'b1000, 4'b0100, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
    vf = '{3'b000, 3'b100, 3'b010, 3'b000, 3'b001, 3'b100, 3'b000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      flags_clr = 1'b1;
      drive(1'b1, va[i], vb[i], vr[i], TAG_W'(i + 3));
      tick();
      flags_clr = 1'b0;
      drive(1'b0, '0, '0, '0, '0);
      total++; if (out_valid !== 1'b1) $display("FAIL cls%0d_valid got=%b exp=1", i, out_valid); else passed++;
      total++; if (out_result !== vr[i]) $display("FAIL cls%0d_result got=%h exp=%h", i, out_result, vr[i]); else passed++;
      total++; if (out_tag !== TAG_W'(i + 3)) $display("FAIL cls%0d_tag got=%0d exp=%0d", i, out_tag, i + 3); else passed++;
      total++; if (out_class !== vc[i]) $display("FAIL cls%0d_class got=%b exp=%b", i, out_class, vc[i]); else passed++;
      total++; if (out_flags !== vf[i]) $display("FAIL cls%0d_flags got=%b exp=%b", i, out_flags, vf[i]); else passed++;
      tick();
      total++; if (sticky_flags !== vf[i]) $display("FAIL cls%0d_sticky got=%b exp=%b", i, sticky_flags, vf[i]); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL cls%0d_drained got=%b exp=0", i, out_valid); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] one;
    one = 64'h3FF0000000000000;
    out_ready = 1'b0;
    drive(1'b1, one, one, one, 4'd1); tick();
    drive(1'b1, one, one, one, 4'd2); tick();
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); else passed++;
    total++; if (count !== 2'd2) $display("FAIL bp_full_count got=%0d exp=2", count); else passed++;
    drive(1'b1, one, one, one, 4'd3); tick();
    total++; if (count !== 2'd2) $display("FAIL bp_stall_count got=%0d exp=2", count); else passed++;
    total++; if (out_tag !== 4'd1) $display("FAIL bp_hold_head got=%0d exp=1", out_tag); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (out_tag !== 4'd2) $display("FAIL bp_order_2 got=%0d exp=2", out_tag); else passed++;
    total++; if (count !== 2'd1) $display("FAIL bp_no_bypass_count got=%0d exp=1", count); else passed++;
    tick();
    total++; if (count !== 2'd1) $display("FAIL bp_pushpop_count got=%0d exp=1", count); else passed++;
    total++; if (out_tag !== 4'd3) $display("FAIL bp_order_3 got=%0d exp=3", out_tag); else passed++;
    drive(1'b0, '0, '0, '0, '0); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_clear_collision();
    out_ready = 1'b1; flags_clr = 1'b1;
    drive(1'b1, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 4'd5);
    tick();
    flags_clr = 1'b0; out_ready = 1'b0;
    drive(1'b1, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000, 4'd6);
    out_ready = 1'b1;
    tick();
    total++; if (sticky_flags !== 3'b100) $display("FAIL clr_pre_sticky got=%b exp=100", sticky_flags); else passed++;
    drive(1'b0, '0, '0, '0, '0);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    total++; if (sticky_flags !== 3'b010) $display("FAIL clr_pop_collision got=%b exp=010", sticky_flags); else passed++;
    flags_clr = 1'b1; tick(); flags_clr = 1'b0;
    total++; if (sticky_flags !== 3'b000) $display("FAIL clr_only got=%b exp=000", sticky_flags); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flags_clr = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 2) != 0, rand_word(), rand_word(), rand_word(), TAG_W'($urandom));
      tick();
      total++; if (count !== 2'(mq.size())) $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); else passed++;
      total++; if (in_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_in_ready c=%0d got=%b", c, in_ready); else passed++;
      total++; if (sticky_flags !== m_sticky) $display("FAIL rnd_sticky c=%0d got=%b exp=%b", c, sticky_flags, m_sticky); else passed++;
      if (mq.size() > 0) begin
        total++;
        if ({out_valid, out_result, out_tag, out_class, out_flags} !==
            {1'b1, mq[0].r, mq[0].tag, mq[0].cls, mq[0].fl})
          $display("FAIL rnd_head c=%0d got=%b/%h/%h/%b/%b exp=1/%h/%h/%b/%b", c, out_valid, out_result,
                   out_tag, out_class, out_flags, mq[0].r, mq[0].tag, mq[0].cls, mq[0].fl);
        else passed++;
      end else begin
        total++; if (out_valid !== 1'b0) $display("FAIL rnd_empty c=%0d got=%b exp=0", c, out_valid); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; flags_clr = 1'b0;
    drive(1'b1, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 4'd9);
    tick(); tick();
    out_ready = 1'b0;
    drive(1'b1, 64'h1, 64'h1, 64'h2, 4'd10); tick();
    drive(1'b1, 64'h1, 64'h1, 64'h2, 4'd11); tick();
    drive(1'b0, '0, '0, '0, '0);
    total++; if ((count !== 2'd2) || (sticky_flags === 3'b000))
      $display("FAIL rstmid_setup count=%0d sticky=%b exp count=2 sticky!=0", count, sticky_flags);
    else passed++;
    rst = 1'b1;
    #1;
    total++; if (count !== 2'd0) $display("FAIL rstmid_count got=%0d exp=0", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", out_valid); else passed++;
    total++; if (sticky_flags !== 3'b000) $display("FAIL rstmid_sticky got=%b exp=000", sticky_flags); else passed++;
    mq.delete(); m_sticky = 3'b000;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL rstmid_post%0d_valid got=%b exp=0", i, out_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_backpressure();
    test_clear_collision();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
